// File: rtl/corner_detector.sv
// Raster-scans one frame from BRAM and reports the four extreme marker pixels (TL/TR/BL/BR).
// Define CORNER_DET_SUBSAMPLE_EN to scan only even x / even y; coordinates stay full resolution.
module corner_detector #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int PIX_W  = 8,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              auto_detection_start,
    output logic              auto_detection_done,
    output logic              busy,
    input  logic [PIX_W-1:0]  threshold,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [9:0]        tl_x,
    output logic [9:0]        tr_x,
    output logic [9:0]        bl_x,
    output logic [9:0]        br_x,
    output logic [8:0]        tl_y,
    output logic [8:0]        tr_y,
    output logic [8:0]        bl_y,
    output logic [8:0]        br_y,
    output logic              corners_valid,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

`ifdef CORNER_DET_SUBSAMPLE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [9:0]        X_LAST   = 10'(H_RES - STEP);
    localparam logic [8:0]        Y_LAST   = 9'(V_RES - STEP);
    localparam logic [9:0]        X_MAX    = 10'(H_RES - 1);
    localparam logic [8:0]        Y_MAX    = 9'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(STEP);
    // Row wrap skips the odd rows when subsampling; equals 1 at full resolution.
    localparam logic [ADDR_W-1:0] ADDR_WRAP_INC = ADDR_W'((STEP - 1) * H_RES + STEP);
    localparam int                DW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT - 1);

    state_t r_state;
    state_t w_next;

    logic              w_accept;
    logic              w_issue;
    logic              w_in_done;
    logic              w_last;

    logic [PIX_W-1:0]  r_thr;
    logic [ADDR_W-1:0] r_addr;
    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic [DW-1:0]     r_drain;
    logic              r_busy;
    logic              r_done;

    logic [RD_LAT-1:0] r_pv;
    logic [9:0]        r_px [RD_LAT];
    logic [8:0]        r_py [RD_LAT];

    logic [9:0]        w_ev_x;
    logic [8:0]        w_ev_y;
    logic              w_mark;
    logic [10:0]       w_s;
    logic [10:0]       w_d;

    logic              r_found;
    logic [10:0]       r_min_s, r_max_s, r_min_d, r_max_d;
    logic [9:0]        r_a_tl_x, r_a_tr_x, r_a_bl_x, r_a_br_x;
    logic [8:0]        r_a_tl_y, r_a_tr_y, r_a_bl_y, r_a_br_y;

    logic [9:0]        r_tl_x, r_tr_x, r_bl_x, r_br_x;
    logic [8:0]        r_tl_y, r_tr_y, r_bl_y, r_br_y;
    logic              r_cv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SCAN;
            S_SCAN:  if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == DRAIN_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // busy still covers the done-pulse cycle, so a start there is ignored.
    always_comb begin
        w_accept  = (r_state == S_IDLE) && auto_detection_start && !r_busy;
        w_issue   = (r_state == S_SCAN);
        w_in_done = (r_state == S_DONE);
        w_last    = (r_x == X_LAST) && (r_y == Y_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_thr   <= '0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= w_in_done;
            r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
            if (w_accept) begin
                r_thr  <= threshold;
                r_addr <= '0;
                r_x    <= '0;
                r_y    <= '0;
                r_busy <= 1'b1;
            end else if (w_issue && !w_last) begin
                if (r_x == X_LAST) begin
                    r_x    <= '0;
                    r_y    <= r_y + 9'(STEP);
                    r_addr <= r_addr + ADDR_WRAP_INC;
                end else begin
                    r_x    <= r_x + 10'(STEP);
                    r_addr <= r_addr + ADDR_INC;
                end
            end
            if (r_done) r_busy <= 1'b0;
        end
    end

    // Coordinates ride alongside the BRAM read so they line up with rd_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            r_pv    <= {r_pv[RD_LAT-1:0], w_issue} >> 0;
            r_px[0] <= r_x;
            r_py[0] <= r_y;
            for (int i = 1; i < RD_LAT; i++) begin
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
            end
        end
    end

    always_comb begin
        w_ev_x = r_px[RD_LAT-1];
        w_ev_y = r_py[RD_LAT-1];
        w_mark = r_pv[RD_LAT-1] && (rd_data >= r_thr);
        w_s    = 11'(w_ev_x) + 11'(w_ev_y);
        w_d    = 11'(w_ev_x) - 11'(w_ev_y) + 11'(V_RES - 1);
    end

    // Strict comparisons keep the raster-first pixel on ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_found <= 1'b0;
            r_min_s <= '0; r_max_s <= '0; r_min_d <= '0; r_max_d <= '0;
            r_a_tl_x <= '0; r_a_tr_x <= '0; r_a_bl_x <= '0; r_a_br_x <= '0;
            r_a_tl_y <= '0; r_a_tr_y <= '0; r_a_bl_y <= '0; r_a_br_y <= '0;
        end else if (w_accept) begin
            r_found <= 1'b0;
        end else if (w_mark) begin
            r_found <= 1'b1;
            if (!r_found || w_s < r_min_s) begin
                r_min_s <= w_s; r_a_tl_x <= w_ev_x; r_a_tl_y <= w_ev_y;
            end
            if (!r_found || w_s > r_max_s) begin
                r_max_s <= w_s; r_a_br_x <= w_ev_x; r_a_br_y <= w_ev_y;
            end
            if (!r_found || w_d > r_max_d) begin
                r_max_d <= w_d; r_a_tr_x <= w_ev_x; r_a_tr_y <= w_ev_y;
            end
            if (!r_found || w_d < r_min_d) begin
                r_min_d <= w_d; r_a_bl_x <= w_ev_x; r_a_bl_y <= w_ev_y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tl_x <= '0;    r_tl_y <= '0;
            r_tr_x <= X_MAX; r_tr_y <= '0;
            r_bl_x <= '0;    r_bl_y <= Y_MAX;
            r_br_x <= X_MAX; r_br_y <= Y_MAX;
            r_cv   <= 1'b0;
        end else if (w_in_done) begin
            r_cv <= r_found;
            if (r_found) begin
                r_tl_x <= r_a_tl_x; r_tl_y <= r_a_tl_y;
                r_tr_x <= r_a_tr_x; r_tr_y <= r_a_tr_y;
                r_bl_x <= r_a_bl_x; r_bl_y <= r_a_bl_y;
                r_br_x <= r_a_br_x; r_br_y <= r_a_br_y;
            end else begin
                r_tl_x <= '0;    r_tl_y <= '0;
                r_tr_x <= X_MAX; r_tr_y <= '0;
                r_bl_x <= '0;    r_bl_y <= Y_MAX;
                r_br_x <= X_MAX; r_br_y <= Y_MAX;
            end
        end
    end

    assign auto_detection_done = r_done;
    assign busy          = r_busy;
    assign rd_addr       = r_addr;
    assign tl_x          = r_tl_x;
    assign tl_y          = r_tl_y;
    assign tr_x          = r_tr_x;
    assign tr_y          = r_tr_y;
    assign bl_x          = r_bl_x;
    assign bl_y          = r_bl_y;
    assign br_x          = r_br_x;
    assign br_y          = r_br_y;
    assign corners_valid = r_cv;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_corner_detector.sv
// Directed bench for corner_detector on a 16x12 frame with a 2-cycle behavioural BRAM.
module tb_corner_detector;

    localparam int H = 16;
    localparam int V = 12;
    localparam int LAT = 196;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       auto_detection_start = 1'b0;
    logic       auto_detection_done;
    logic       busy;
    logic [7:0] threshold = 8'd0;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [9:0] tl_x, tr_x, bl_x, br_x;
    logic [8:0] tl_y, tr_y, bl_y, br_y;
    logic       corners_valid;
    logic [1:0] o_dbg_state;

    logic [7:0] mem [256];
    logic [7:0] pipe0, pipe1;

    int errors = 0;
    int checks = 0;

    corner_detector #(.H_RES(H), .V_RES(V), .PIX_W(8), .RD_LAT(2), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .auto_detection_start(auto_detection_start), .auto_detection_done(auto_detection_done),
        .busy(busy), .threshold(threshold), .rd_addr(rd_addr), .rd_data(rd_data),
        .tl_x(tl_x), .tr_x(tr_x), .bl_x(bl_x), .br_x(br_x),
        .tl_y(tl_y), .tr_y(tr_y), .bl_y(bl_y), .br_y(br_y),
        .corners_valid(corners_valid), .o_dbg_state(o_dbg_state)
    );

    // clock / BRAM model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe0 <= mem[rd_addr];
        pipe1 <= pipe0;
    end
    assign rd_data = pipe1;

    function automatic logic [75:0] corners(input int ax, ay, bx, by, cx, cy, dx, dy);
        return {10'(ax), 9'(ay), 10'(bx), 9'(by), 10'(cx), 9'(cy), 10'(dx), 9'(dy)};
    endfunction

    function automatic logic [75:0] got_corners();
        return {tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    endtask

    task automatic set_pix(input int x, input int y, input logic [7:0] v);
        mem[y * H + x] = v;
    endtask

    // Called #1 after a clock edge; returns cycles from start to done (-1 on timeout).
    task automatic run_scan(input int mid_start_at, output int cyc, output bit busy_hi);
        int n;
        busy_hi = 1'b1;
        cyc = -1;
        n = 0;
        auto_detection_start = 1'b1;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            auto_detection_start = (n == mid_start_at);
            if (!busy) busy_hi = 1'b0;
            if (auto_detection_done) begin
                cyc = n;
                break;
            end
        end
        auto_detection_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if ({busy, auto_detection_done, corners_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, auto_detection_done, corners_valid});
        end
        checks++;
        if (rd_addr !== 8'd0) begin
            errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr);
        end
        checks++;
        if (got_corners() !== corners(0, 0, 15, 0, 0, 11, 15, 11)) begin
            errors++; $display("FAIL reset_corners: got %h expected %h", got_corners(), corners(0, 0, 15, 0, 0, 11, 15, 11));
        end
        checks++;
        if (o_dbg_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state);
        end
        checks++;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty_frame();
        int cyc; bit bh;
        clear_mem();
        threshold = 8'd8;
        run_scan(0, cyc, bh);
        if (cyc !== LAT) begin
            errors++; $display("FAIL empty_latency: got %0d expected %0d", cyc, LAT);
        end
        checks++;
        if (bh !== 1'b1) begin
            errors++; $display("FAIL empty_busy: got busy_held=%0d expected 1", bh);
        end
        checks++;
        @(posedge clk); #1;
        if ({auto_detection_done, busy} !== 2'b00) begin
            errors++; $display("FAIL empty_done_pulse: got done,busy=%b expected 00", {auto_detection_done, busy});
        end
        checks++;
        if (corners_valid !== 1'b0) begin
            errors++; $display("FAIL empty_valid: got %0d expected 0", corners_valid);
        end
        checks++;
        if (got_corners() !== corners(0, 0, 15, 0, 0, 11, 15, 11)) begin
            errors++; $display("FAIL empty_corners: got %h expected %h", got_corners(), corners(0, 0, 15, 0, 0, 11, 15, 11));
        end
        checks++;
    endtask

    task automatic test_single_pixel();
        int cyc; bit bh;
        clear_mem();
        set_pix(5, 3, 8'd200);
        threshold = 8'd100;
        run_scan(0, cyc, bh);
        if (cyc !== LAT) begin
            errors++; $display("FAIL single_latency: got %0d expected %0d", cyc, LAT);
        end
        checks++;
        @(posedge clk); #1;
        if (auto_detection_done !== 1'b0) begin
            errors++; $display("FAIL single_done_pulse: got %0d expected 0", auto_detection_done);
        end
        checks++;
        if (corners_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid: got %0d expected 1", corners_valid);
        end
        checks++;
        if (got_corners() !== corners(5, 3, 5, 3, 5, 3, 5, 3)) begin
            errors++; $display("FAIL single_corners: got %h expected %h", got_corners(), corners(5, 3, 5, 3, 5, 3, 5, 3));
        end
        checks++;
    endtask

    task automatic load_four();
        clear_mem();
        set_pix(2, 1, 8'd150);
        set_pix(13, 2, 8'd100);
        set_pix(1, 10, 8'd255);
        set_pix(14, 9, 8'd180);
        set_pix(7, 6, 8'd99);
        threshold = 8'd100;
    endtask

    task automatic test_four_corners();
        int cyc; bit bh;
        load_four();
        run_scan(0, cyc, bh);
        if (cyc !== LAT) begin
            errors++; $display("FAIL four_latency: got %0d expected %0d", cyc, LAT);
        end
        checks++;
        @(posedge clk); #1;
        if (got_corners() !== corners(2, 1, 13, 2, 1, 10, 14, 9)) begin
            errors++; $display("FAIL four_corners: got %h expected %h", got_corners(), corners(2, 1, 13, 2, 1, 10, 14, 9));
        end
        checks++;
        if (corners_valid !== 1'b1) begin
            errors++; $display("FAIL four_valid: got %0d expected 1", corners_valid);
        end
        checks++;
    endtask

    task automatic test_tie();
        int cyc; bit bh;
        clear_mem();
        set_pix(3, 0, 8'd120);
        set_pix(0, 3, 8'd120);
        threshold = 8'd100;
        run_scan(0, cyc, bh);
        @(posedge clk); #1;
        if (got_corners() !== corners(3, 0, 3, 0, 0, 3, 3, 0)) begin
            errors++; $display("FAIL tie_corners: got %h expected %h", got_corners(), corners(3, 0, 3, 0, 0, 3, 3, 0));
        end
        checks++;
    endtask

    task automatic test_start_ignored();
        int cyc; int extra; bit bh;
        load_four();
        run_scan(60, cyc, bh);
        if (cyc !== LAT) begin
            errors++; $display("FAIL midstart_latency: got %0d expected %0d", cyc, LAT);
        end
        checks++;
        if (bh !== 1'b1) begin
            errors++; $display("FAIL midstart_busy: got busy_held=%0d expected 1", bh);
        end
        checks++;
        extra = 0;
        repeat (250) begin
            @(posedge clk); #1;
            if (auto_detection_done) extra++;
        end
        if (extra !== 0) begin
            errors++; $display("FAIL midstart_extra_done: got %0d expected 0", extra);
        end
        checks++;
    endtask

    task automatic test_start_at_done();
        int cyc; bit bh; int busy_seen;
        load_four();
        run_scan(0, cyc, bh);
        auto_detection_start = 1'b1;
        @(posedge clk); #1;
        auto_detection_start = 1'b0;
        busy_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy) busy_seen++;
        end
        if (busy_seen !== 0) begin
            errors++; $display("FAIL start_at_done: got busy cycles %0d expected 0", busy_seen);
        end
        checks++;
    endtask

    task automatic test_reset_mid_scan();
        int cyc; int dones; bit bh;
        clear_mem();
        set_pix(3, 0, 8'd120);
        set_pix(0, 3, 8'd120);
        threshold = 8'd100;
        auto_detection_start = 1'b1;
        @(posedge clk); #1;
        auto_detection_start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        if ({busy, auto_detection_done, corners_valid} !== 3'b000) begin
            errors++; $display("FAIL midreset_flags: got %b expected 000", {busy, auto_detection_done, corners_valid});
        end
        checks++;
        if (rd_addr !== 8'd0) begin
            errors++; $display("FAIL midreset_rd_addr: got %0d expected 0", rd_addr);
        end
        checks++;
        if (got_corners() !== corners(0, 0, 15, 0, 0, 11, 15, 11)) begin
            errors++; $display("FAIL midreset_corners: got %h expected %h", got_corners(), corners(0, 0, 15, 0, 0, 11, 15, 11));
        end
        checks++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        dones = 0;
        repeat (250) begin
            @(posedge clk); #1;
            if (auto_detection_done || busy) dones++;
        end
        if (dones !== 0) begin
            errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", dones);
        end
        checks++;
        load_four();
        run_scan(0, cyc, bh);
        if (cyc !== LAT) begin
            errors++; $display("FAIL postreset_latency: got %0d expected %0d", cyc, LAT);
        end
        checks++;
        @(posedge clk); #1;
        if (got_corners() !== corners(2, 1, 13, 2, 1, 10, 14, 9)) begin
            errors++; $display("FAIL postreset_corners: got %h expected %h", got_corners(), corners(2, 1, 13, 2, 1, 10, 14, 9));
        end
        checks++;
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_empty_frame();
        test_single_pixel();
        test_four_corners();
        test_tie();
        test_start_ignored();
        test_start_at_done();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
